// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master/decoder/multiplexor and the SRAM slave.
// Handshake: an address phase is taken on a rising edge where sel=1, ready=1 and
// trans is NONSEQ/SEQ; its data phase ends on the first edge where readyout=1.
interface ahb_sram_slave_if #(
  parameter int AHB_DATA_WIDTH = 32,
  parameter int AHB_ADDR_WIDTH = 32
);
  logic                      ahb_sel_in;
  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in;
  logic [1:0]                ahb_trans_in;
  logic                      ahb_write_in;
  logic [2:0]                ahb_size_in;
  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in;
  logic                      ahb_ready_in;
  logic [AHB_DATA_WIDTH-1:0] slave_rdata_out;
  logic                      slave_readyout_out;
  logic                      slave_resp_out;

  modport slave (
    input  ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_write_in, ahb_size_in,
           ahb_wdata_in, ahb_ready_in,
    output slave_rdata_out, slave_readyout_out, slave_resp_out
  );

  modport master (
    output ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_write_in, ahb_size_in,
           ahb_wdata_in, ahb_ready_in,
    input  slave_rdata_out, slave_readyout_out, slave_resp_out
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: flop-array storage, programmable wait states, byte-lane writes.
// Define AHB_SRAM_SLAVE_ERR_EN to answer bad transfers with a two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int AHB_DATA_WIDTH = 32,
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH      = 16,
  parameter int WAIT_CYCLES    = 1
) (
  input  logic            ahb_clk_in,
  input  logic            ahb_rstn_in,
  ahb_sram_slave_if.slave bus,
  output logic [2:0]      o_dbg_state
);
  localparam int         BYTES     = AHB_DATA_WIDTH / 8;
  localparam int         OFF_W     = $clog2(BYTES);
  localparam int         IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE  = 3'(OFF_W);
  localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

`ifdef AHB_SRAM_SLAVE_ERR_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_WAIT = 3'd1, ST_DATA = 3'd2, ST_ERR1 = 3'd3, ST_ERR2 = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_WAIT = 3'd1, ST_DATA = 3'd2
  } state_t;
`endif

  state_t                    r_state;
  state_t                    w_next_state;
  state_t                    w_target;
  logic [IDX_W-1:0]          r_idx;
  logic [OFF_W-1:0]          r_off;
  logic [2:0]                r_size;
  logic                      r_write;
  logic                      r_err;
  logic [2:0]                r_wait_cnt;
  logic [AHB_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                      w_readyout;
  logic                      w_resp;
  logic                      w_active;
  logic                      w_accept;
  logic                      w_oor;
  logic                      w_too_wide;
  logic                      w_misalign;
  logic                      w_err;
  logic [7:0]                w_align_mask;
  logic [IDX_W-1:0]          w_idx;
  logic [OFF_W-1:0]          w_off;
  logic                      w_mem_we;
  logic [BYTES-1:0]          w_lane_mask;

`ifdef AHB_SRAM_SLAVE_ERR_EN
  assign w_readyout = (r_state != ST_WAIT) && (r_state != ST_ERR1);
  assign w_resp     = (r_state == ST_ERR1) || (r_state == ST_ERR2);
`else
  assign w_readyout = (r_state != ST_WAIT);
  assign w_resp     = 1'b0;
`endif

  // Only states that are driving readyout=1 can be finishing a data phase, so only they take a new address.
  assign w_active = (bus.ahb_trans_in == 2'b10) || (bus.ahb_trans_in == 2'b11);
  assign w_accept = bus.ahb_sel_in && bus.ahb_ready_in && w_active && w_readyout;

  assign w_oor        = (bus.ahb_addr_in >> (IDX_W + OFF_W)) != '0;
  assign w_too_wide   = bus.ahb_size_in > MAX_SIZE;
  assign w_align_mask = (8'd1 << bus.ahb_size_in) - 8'd1;
  assign w_misalign   = (bus.ahb_addr_in[7:0] & w_align_mask) != 8'd0;
  assign w_err        = w_oor || w_too_wide || w_misalign;
  assign w_idx        = bus.ahb_addr_in[IDX_W+OFF_W-1:OFF_W];
  assign w_off        = bus.ahb_addr_in[OFF_W-1:0];

  always_comb begin
    w_target = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DATA;
`ifdef AHB_SRAM_SLAVE_ERR_EN
    if (w_err) begin
      w_target = ST_ERR1;
    end
`endif
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = w_target;
      ST_WAIT: if (r_wait_cnt == 3'd0) w_next_state = ST_DATA;
      ST_DATA: w_next_state = w_accept ? w_target : ST_IDLE;
`ifdef AHB_SRAM_SLAVE_ERR_EN
      ST_ERR1: w_next_state = ST_ERR2;
      ST_ERR2: w_next_state = w_accept ? w_target : ST_IDLE;
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_off      <= '0;
      r_size     <= 3'd0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_wait_cnt <= 3'd0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_idx      <= w_idx;
        r_off      <= w_off;
        r_size     <= bus.ahb_size_in;
        r_write    <= bus.ahb_write_in;
        r_err      <= w_err;
        r_wait_cnt <= WAIT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != 3'd0)) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end
    end
  end

  // A flagged transfer never touches storage; without error responses it simply completes OKAY.
  assign w_mem_we = (r_state == ST_DATA) && r_write && !r_err;

  always_comb begin
    w_lane_mask = '0;
    for (int b = 0; b < BYTES; b++) begin
      w_lane_mask[b] = (b >= int'(r_off)) && (b < (int'(r_off) + (1 << r_size)));
    end
  end

  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_lane_mask[b]) begin
          r_mem[r_idx][b*8 +: 8] <= bus.ahb_wdata_in[b*8 +: 8];
        end
      end
    end
  end

  assign bus.slave_rdata_out    = ((r_state == ST_DATA) && !r_write && !r_err) ? r_mem[r_idx] : '0;
  assign bus.slave_readyout_out = w_readyout;
  assign bus.slave_resp_out     = w_resp;
  assign o_dbg_state            = r_state;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: directed and random AHB transfers against a byte-array model.
module tb_ahb_sram_slave;
  localparam int DW        = 32;
  localparam int AW        = 32;
  localparam int DEPTH     = 16;
  localparam int WAITS     = 1;
  localparam int DBYTES    = DW / 8;
  localparam int MEM_BYTES = DEPTH * DBYTES;
`ifdef AHB_SRAM_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    dbg_state;
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [7:0]    m_mem [MEM_BYTES];
  logic [AW-1:0] t_addr [$];
  logic          t_write [$];
  logic [2:0]    t_size [$];
  logic [DW-1:0] t_data [$];
  logic [DW-1:0] last_rdata;

  ahb_sram_slave_if #(.AHB_DATA_WIDTH(DW), .AHB_ADDR_WIDTH(AW)) bus ();

  ahb_sram_slave #(
    .AHB_DATA_WIDTH(DW), .AHB_ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(WAITS)
  ) dut (
    .ahb_clk_in (clk),
    .ahb_rstn_in(rst_n),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // Single-slave system: the multiplexor returns this slave's readyout as HREADY.
  assign bus.ahb_ready_in = bus.slave_readyout_out;

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_err(input logic [AW-1:0] a, input logic [2:0] sz);
    longint nb = longint'(1) << sz;
    return (nb > DBYTES) || ((longint'(a) % nb) != 0) || (longint'(a) >= MEM_BYTES);
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    int base = (int'(a) / DBYTES) * DBYTES;
    logic [DW-1:0] w = '0;
    for (int b = 0; b < DBYTES; b++) w[b*8 +: 8] = m_mem[base + b];
    return w;
  endfunction

  task automatic m_write(input logic [AW-1:0] a, input logic [2:0] sz, input logic [DW-1:0] d);
    int lane = int'(a) % DBYTES;
    for (int b = 0; b < (1 << sz); b++) m_mem[int'(a) + b] = d[(lane + b)*8 +: 8];
  endtask

  task automatic add(input logic [AW-1:0] a, input logic w, input logic [2:0] sz, input logic [DW-1:0] d);
    t_addr.push_back(a);
    t_write.push_back(w);
    t_size.push_back(sz);
    t_data.push_back(d);
  endtask

  task automatic bus_idle();
    bus.ahb_sel_in   = 1'b0;
    bus.ahb_trans_in = 2'b00;
  endtask

  task automatic drive_addr(input int i);
    if (i < t_addr.size()) begin
      bus.ahb_sel_in   = 1'b1;
      bus.ahb_trans_in = (i == 0) ? 2'b10 : 2'b11;
      bus.ahb_addr_in  = t_addr[i];
      bus.ahb_write_in = t_write[i];
      bus.ahb_size_in  = t_size[i];
    end else begin
      bus_idle();
    end
  endtask

  // Issues the queued transfers back to back (next address during current data phase)
  // and checks every data-phase cycle against the model. Called just after a rising edge.
  task automatic run();
    int n = t_addr.size();
    int cur = -1;
    int nxt = 0;
    int waits = 0;
    int cyc = 0;
    int exp_cyc = 1;
    int exp_w;
    bit e;
    logic ro, rsp;
    logic [DW-1:0] rd;
    for (int i = 0; i < n; i++) exp_cyc += (ERR_EN && m_err(t_addr[i], t_size[i])) ? 2 : WAITS + 1;
    drive_addr(0);
    while (1) begin
      @(negedge clk);
      ro  = bus.slave_readyout_out;
      rsp = bus.slave_resp_out;
      rd  = bus.slave_rdata_out;
      if (cur >= 0) begin
        e     = m_err(t_addr[cur], t_size[cur]);
        exp_w = (ERR_EN && e) ? 1 : WAITS;
        if (!ro) begin
          waits++;
          check("wait_resp", 64'(rsp), 64'(ERR_EN && e));
          check("wait_rdata", 64'(rd), 64'(0));
        end else begin
          check("wait_count", 64'(waits), 64'(exp_w));
          check("data_resp", 64'(rsp), 64'(ERR_EN && e));
          if (t_write[cur]) begin
            check("wr_rdata", 64'(rd), 64'(0));
            if (!e) m_write(t_addr[cur], t_size[cur], t_data[cur]);
          end else begin
            check("rd_rdata", 64'(rd), e ? 64'(0) : 64'(m_read(t_addr[cur])));
            last_rdata = rd;
          end
        end
      end
      @(posedge clk);
      cyc++;
      if (ro) begin
        cur = (nxt < n) ? nxt : -1;
        nxt++;
        waits = 0;
      end
      if ((cur < 0) && (nxt >= n)) break;
      if (cyc > exp_cyc + 16) begin
        check("cycle_budget", 64'(cyc), 64'(exp_cyc));
        break;
      end
      #1;
      if (ro) begin
        drive_addr(nxt);
        if (cur >= 0) bus.ahb_wdata_in = t_data[cur];
      end
    end
    check("burst_cycles", 64'(cyc), 64'(exp_cyc));
    #1;
    bus_idle();
    t_addr.delete();
    t_write.delete();
    t_size.delete();
    t_data.delete();
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [2:0]    sz;
    int            nb;
    bus_idle();
    bus.ahb_addr_in  = '0;
    bus.ahb_write_in = 1'b0;
    bus.ahb_size_in  = 3'd0;
    bus.ahb_wdata_in = '0;
    last_rdata       = '0;
    for (int i = 0; i < MEM_BYTES; i++) m_mem[i] = 8'h00;

    #2;
    check("rst_readyout", 64'(bus.slave_readyout_out), 64'(1));
    check("rst_resp", 64'(bus.slave_resp_out), 64'(0));
    check("rst_rdata", 64'(bus.slave_rdata_out), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // First address phase straight out of reset, then read-back.
    add(32'h8, 1'b1, 3'd2, 32'hDEADBEEF);
    run();
    add(32'h8, 1'b0, 3'd2, '0);
    run();
    check("deadbeef", 64'(last_rdata), 64'(32'hDEADBEEF));

    // Byte lane 1 over a zeroed word.
    add(32'h5, 1'b1, 3'd0, 32'h0000AA00);
    run();
    add(32'h4, 1'b0, 3'd2, '0);
    run();
    check("byte_lane", 64'(last_rdata), 64'(32'h0000AA00));

    // Out-of-range read.
    add(32'h100, 1'b0, 3'd2, '0);
    run();
    check("oor_rdata", 64'(last_rdata), 64'(0));

    // Misaligned halfword write must not disturb the word; pipelined through the error.
    add(32'h0, 1'b1, 3'd2, 32'h11223344);
    add(32'h3, 1'b1, 3'd1, 32'h55667788);
    add(32'h0, 1'b0, 3'd2, '0);
    run();
    check("misalign_keep", 64'(last_rdata), 64'(32'h11223344));

    // Back-to-back pipelined writes and reads.
    add(32'h0, 1'b1, 3'd2, 32'hCAFE0001);
    add(32'h4, 1'b1, 3'd2, 32'hCAFE0004);
    add(32'h0, 1'b0, 3'd2, '0);
    add(32'h4, 1'b0, 3'd2, '0);
    run();
    check("pipe_word4", 64'(last_rdata), 64'(32'hCAFE0004));

    // BUSY and IDLE while selected: zero-wait OKAY, no data.
    bus.ahb_sel_in   = 1'b1;
    bus.ahb_trans_in = 2'b01;
    @(posedge clk);
    #1;
    check("busy_readyout", 64'(bus.slave_readyout_out), 64'(1));
    check("busy_resp", 64'(bus.slave_resp_out), 64'(0));
    check("busy_rdata", 64'(bus.slave_rdata_out), 64'(0));
    bus.ahb_trans_in = 2'b00;
    @(posedge clk);
    #1;
    check("idle_readyout", 64'(bus.slave_readyout_out), 64'(1));
    check("idle_rdata", 64'(bus.slave_rdata_out), 64'(0));
    bus_idle();

    // Random bursts over in-range, out-of-range, misaligned and oversized transfers.
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
        sz = 3'($urandom_range(0, 3));
        nb = 1 << sz;
        a  = AW'($urandom_range(0, MEM_BYTES + 15));
        if ($urandom_range(0, 3) != 0) a = a & ~(AW'(nb - 1));
        if ($urandom_range(0, 9) == 0) a = a | 32'h8000_0000;
        add(a, 1'($urandom_range(0, 1)), sz, DW'($urandom));
      end
      run();
    end

    // Reset in the middle of a wait state.
    bus.ahb_sel_in   = 1'b1;
    bus.ahb_trans_in = 2'b10;
    bus.ahb_addr_in  = 32'h8;
    bus.ahb_write_in = 1'b0;
    bus.ahb_size_in  = 3'd2;
    @(posedge clk);
    #1;
    bus_idle();
    check("in_wait_readyout", 64'(bus.slave_readyout_out), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_readyout", 64'(bus.slave_readyout_out), 64'(1));
    check("midrst_resp", 64'(bus.slave_resp_out), 64'(0));
    check("midrst_rdata", 64'(bus.slave_rdata_out), 64'(0));
    for (int i = 0; i < MEM_BYTES; i++) m_mem[i] = 8'h00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    add(32'h0, 1'b0, 3'd2, '0);
    add(32'h8, 1'b1, 3'd2, 32'h0BADF00D);
    add(32'h8, 1'b0, 3'd2, '0);
    run();
    check("post_reset_rd", 64'(last_rdata), 64'(32'h0BADF00D));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
